// File: rtl/rtc_pkg.sv
// Shared types and BCD helpers for the RTC bus arbiter (see RTC_RANGE_CHECK_EN in the top).
package rtc_pkg;

    typedef enum logic [1:0] {IDLE, ISSUE, CONV, DONE} state_t;
    typedef enum logic {PICO, SCAN} owner_t;

    localparam logic [7:0] BCD_MAX = 8'h99;

    // Values above 99 have no two-digit BCD form and map to 00.
    function automatic logic [7:0] bin2bcd(input logic [7:0] v);
        logic [3:0] tens;
        logic [3:0] units;
        tens  = 4'(v / 8'd10);
        units = 4'(v % 8'd10);
        if (v > 8'd99) return 8'h00;
        return {tens, units};
    endfunction

    function automatic logic [7:0] bcd2bin(input logic [7:0] b);
        return ({4'b0000, b[7:4]} * 8'd10) + {4'b0000, b[3:0]};
    endfunction

    function automatic logic bcd_invalid(input logic [7:0] b);
        return (b[7:4] > BCD_MAX[7:4]) || (b[3:0] > BCD_MAX[3:0]);
    endfunction

endpackage

// File: rtl/bcd_conv.sv
// Combinational binary<->BCD converter shared by the write and read paths.
module bcd_conv
    import rtc_pkg::*;
(
    input  logic [7:0] bin_in,
    output logic [7:0] bcd_out,
    input  logic [7:0] bcd_in,
    output logic [7:0] bin_out,
    output logic       bcd_bad
);

    assign bcd_out = bin2bcd(bin_in);
    assign bin_out = bcd2bin(bcd_in);
    assign bcd_bad = bcd_invalid(bcd_in);

endmodule

// File: rtl/rtc_bus_arbiter.sv
// Round-robin arbiter between PicoBlaze and display scanner for the BCD RTC bus.
// Define RTC_RANGE_CHECK_EN to reject values above LIMIT and raise conv_err.
module rtc_bus_arbiter
    import rtc_pkg::*;
#(
    parameter int ADDR_W      = 8,
    parameter int SCAN_PERIOD = 50000,
    parameter int SCAN_REGS   = 3,
    parameter int LIMIT       = 59
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              pico_req,
    input  logic              pico_we,
    input  logic [ADDR_W-1:0] pico_addr,
    input  logic [7:0]        pico_wdata,
    output logic              pico_busy,
    output logic              pico_done,
    output logic [7:0]        pico_rdata,
    input  logic              scan_en,
    output logic              upd_valid,
    output logic [ADDR_W-1:0] upd_addr,
    output logic [7:0]        upd_data,
    output logic              rtc_req,
    output logic              rtc_we,
    output logic [ADDR_W-1:0] rtc_addr,
    output logic [7:0]        rtc_wdata,
    input  logic [7:0]        rtc_rdata,
    input  logic              rtc_ack,
    output logic              conv_err
);

    localparam int CNT_W = (SCAN_PERIOD > 1) ? $clog2(SCAN_PERIOD) : 1;
    localparam int PTR_W = (SCAN_REGS > 1) ? $clog2(SCAN_REGS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_PERIOD - 1);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(SCAN_REGS - 1);
    localparam logic [7:0] LIM8 = 8'(LIMIT);

    state_t state_q, state_d;
    owner_t owner_q, owner_d, last_grant_q, last_grant_d;
    logic we_q, we_d, rtc_req_q, rtc_req_d;
    logic [ADDR_W-1:0] addr_q, addr_d, upd_addr_q, upd_addr_d;
    logic [7:0] wdata_q, wdata_d, rdata_q, rdata_d;
    logic pico_busy_q, pico_busy_d, pico_done_q, pico_done_d;
    logic [7:0] pico_rdata_q, pico_rdata_d, upd_data_q, upd_data_d;
    logic upd_valid_q, upd_valid_d, conv_err_q, conv_err_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [PTR_W-1:0] scan_ptr_q, scan_ptr_d;
    logic scan_pend_q, scan_pend_d;
    logic pend_q, pend_d, pend_we_q, pend_we_d;
    logic [ADDR_W-1:0] pend_addr_q, pend_addr_d;
    logic [7:0] pend_wdata_q, pend_wdata_d;

    logic scan_tick, pico_take, pico_cand, cur_we;
    logic [ADDR_W-1:0] cur_addr;
    logic [7:0] cur_wbin, conv_bcd, conv_bin, read_result;
    logic conv_bad, read_err, wr_reject;

    // A request arriving while the bus is busy with a scan is held until IDLE.
    assign pico_take = pico_req && !pico_busy_q;
    assign pico_cand = pend_q || pico_take;
    assign cur_we    = pend_q ? pend_we_q    : pico_we;
    assign cur_addr  = pend_q ? pend_addr_q  : pico_addr;
    assign cur_wbin  = pend_q ? pend_wdata_q : pico_wdata;

    bcd_conv u_conv (
        .bin_in  (cur_wbin),
        .bcd_out (conv_bcd),
        .bcd_in  (rdata_q),
        .bin_out (conv_bin),
        .bcd_bad (conv_bad)
    );

`ifdef RTC_RANGE_CHECK_EN
    assign read_err  = conv_bad || (conv_bin > LIM8);
    assign wr_reject = cur_we && (cur_wbin > LIM8);
`else
    logic unused_range;
    assign unused_range = ^{conv_bad, LIM8};
    assign read_err  = 1'b0;
    assign wr_reject = 1'b0;
`endif

    assign read_result = read_err ? 8'h00 : conv_bin;

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_grant_d = last_grant_q;
        we_d         = we_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        rdata_d      = rdata_q;
        rtc_req_d    = rtc_req_q;
        pico_busy_d  = pico_busy_q;
        pico_rdata_d = pico_rdata_q;
        upd_addr_d   = upd_addr_q;
        upd_data_d   = upd_data_q;
        scan_ptr_d   = scan_ptr_q;
        scan_pend_d  = scan_pend_q;
        pend_d       = pend_q;
        pend_we_d    = pend_we_q;
        pend_addr_d  = pend_addr_q;
        pend_wdata_d = pend_wdata_q;
        pico_done_d  = 1'b0;
        upd_valid_d  = 1'b0;
        conv_err_d   = 1'b0;
        scan_tick    = 1'b0;

        if (!scan_en) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            cnt_d     = '0;
            scan_tick = 1'b1;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
        if (scan_tick) scan_pend_d = 1'b1;

        if (pico_take) begin
            pend_d       = 1'b1;
            pend_we_d    = pico_we;
            pend_addr_d  = pico_addr;
            pend_wdata_d = pico_wdata;
            pico_busy_d  = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (pico_cand && (!scan_pend_q || last_grant_q == SCAN)) begin
                    owner_d      = PICO;
                    last_grant_d = PICO;
                    pend_d       = 1'b0;
                    we_d         = cur_we;
                    addr_d       = cur_addr;
                    wdata_d      = conv_bcd;
                    if (wr_reject) begin
                        state_d     = DONE;
                        pico_done_d = 1'b1;
                        conv_err_d  = 1'b1;
                    end else begin
                        state_d   = ISSUE;
                        rtc_req_d = 1'b1;
                    end
                end else if (scan_pend_q) begin
                    owner_d      = SCAN;
                    last_grant_d = SCAN;
                    we_d         = 1'b0;
                    addr_d       = ADDR_W'(scan_ptr_q);
                    wdata_d      = 8'h00;
                    state_d      = ISSUE;
                    rtc_req_d    = 1'b1;
                end
            end
            ISSUE: begin
                if (rtc_ack) begin
                    rdata_d   = rtc_rdata;
                    rtc_req_d = 1'b0;
                    state_d   = CONV;
                end
            end
            CONV: begin
                state_d    = DONE;
                conv_err_d = read_err && !we_q;
                if (owner_q == PICO) begin
                    pico_done_d = 1'b1;
                    if (!we_q) pico_rdata_d = read_result;
                end else begin
                    upd_valid_d = 1'b1;
                    upd_addr_d  = addr_q;
                    upd_data_d  = read_result;
                end
            end
            DONE: begin
                state_d = IDLE;
                if (owner_q == PICO) begin
                    pico_busy_d = 1'b0;
                end else if (scan_ptr_q == PTR_LAST) begin
                    scan_ptr_d  = '0;
                    scan_pend_d = 1'b0;
                end else begin
                    scan_ptr_d = scan_ptr_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            owner_q      <= PICO;
            last_grant_q <= SCAN;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= 8'h00;
            rdata_q      <= 8'h00;
            rtc_req_q    <= 1'b0;
            pico_busy_q  <= 1'b0;
            pico_done_q  <= 1'b0;
            pico_rdata_q <= 8'h00;
            upd_valid_q  <= 1'b0;
            upd_addr_q   <= '0;
            upd_data_q   <= 8'h00;
            conv_err_q   <= 1'b0;
            cnt_q        <= '0;
            scan_ptr_q   <= '0;
            scan_pend_q  <= 1'b0;
            pend_q       <= 1'b0;
            pend_we_q    <= 1'b0;
            pend_addr_q  <= '0;
            pend_wdata_q <= 8'h00;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            rdata_q      <= rdata_d;
            rtc_req_q    <= rtc_req_d;
            pico_busy_q  <= pico_busy_d;
            pico_done_q  <= pico_done_d;
            pico_rdata_q <= pico_rdata_d;
            upd_valid_q  <= upd_valid_d;
            upd_addr_q   <= upd_addr_d;
            upd_data_q   <= upd_data_d;
            conv_err_q   <= conv_err_d;
            cnt_q        <= cnt_d;
            scan_ptr_q   <= scan_ptr_d;
            scan_pend_q  <= scan_pend_d;
            pend_q       <= pend_d;
            pend_we_q    <= pend_we_d;
            pend_addr_q  <= pend_addr_d;
            pend_wdata_q <= pend_wdata_d;
        end
    end

    assign pico_busy  = pico_busy_q;
    assign pico_done  = pico_done_q;
    assign pico_rdata = pico_rdata_q;
    assign upd_valid  = upd_valid_q;
    assign upd_addr   = upd_addr_q;
    assign upd_data   = upd_data_q;
    assign rtc_req    = rtc_req_q;
    assign rtc_we     = we_q;
    assign rtc_addr   = addr_q;
    assign rtc_wdata  = wdata_q;
    assign conv_err   = conv_err_q;

endmodule

// File: tb/tb_rtc_bus_arbiter.sv
// Scoreboard bench for rtc_bus_arbiter; honours RTC_RANGE_CHECK_EN for expected values.
module tb_rtc_bus_arbiter;

`ifdef RTC_RANGE_CHECK_EN
    localparam bit RC = 1'b1;
`else
    localparam bit RC = 1'b0;
`endif

    typedef struct {
        logic [7:0] rdata;
        logic       err;
        int         latMode;
        int         reqEdge;
    } picoExp_t;

    typedef struct {
        logic [7:0] addr;
        logic [7:0] data;
        logic       err;
    } updExp_t;

    typedef struct {
        logic [7:0] addr;
        logic [7:0] wdata;
    } busExp_t;

    logic       clk;
    logic       rst_n;
    logic       pico_req;
    logic       pico_we;
    logic [7:0] pico_addr;
    logic [7:0] pico_wdata;
    logic       pico_busy;
    logic       pico_done;
    logic [7:0] pico_rdata;
    logic       scan_en;
    logic       upd_valid;
    logic [7:0] upd_addr;
    logic [7:0] upd_data;
    logic       rtc_req;
    logic       rtc_we;
    logic [7:0] rtc_addr;
    logic [7:0] rtc_wdata;
    logic [7:0] rtc_rdata;
    logic       rtc_ack;
    logic       conv_err;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int lastAckEdge = 0;
    int doneCount = 0;
    int updCount = 0;
    int ackDelay = 0;
    bit respEnable = 1'b1;
    logic [7:0] regs [0:7];

    picoExp_t picoQ[$];
    updExp_t  updQ[$];
    busExp_t  busQ[$];
    byte      orderQ[$];

    rtc_bus_arbiter #(
        .ADDR_W      (8),
        .SCAN_PERIOD (16),
        .SCAN_REGS   (3),
        .LIMIT       (59)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .pico_req   (pico_req),
        .pico_we    (pico_we),
        .pico_addr  (pico_addr),
        .pico_wdata (pico_wdata),
        .pico_busy  (pico_busy),
        .pico_done  (pico_done),
        .pico_rdata (pico_rdata),
        .scan_en    (scan_en),
        .upd_valid  (upd_valid),
        .upd_addr   (upd_addr),
        .upd_data   (upd_data),
        .rtc_req    (rtc_req),
        .rtc_we     (rtc_we),
        .rtc_addr   (rtc_addr),
        .rtc_wdata  (rtc_wdata),
        .rtc_rdata  (rtc_rdata),
        .rtc_ack    (rtc_ack),
        .conv_err   (conv_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h expected=%0h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    // Queue the expected completion (and bus write) then pulse one pico request.
    task automatic applyStimulus(input logic we, input logic [7:0] addr, input logic [7:0] wdata,
                                 input logic [7:0] expRdata, input logic expErr, input int latMode,
                                 input logic busWrite, input logic [7:0] busData);
        picoExp_t p;
        busExp_t b;
        int n;
        n = 0;
        while (pico_busy && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        checkOutput("busy_release", 32'(pico_busy), 32'd0);
        p.rdata = expRdata;
        p.err = expErr;
        p.latMode = latMode;
        p.reqEdge = cyc + 1;
        picoQ.push_back(p);
        if (busWrite) begin
            b.addr = addr;
            b.wdata = busData;
            busQ.push_back(b);
        end
        pico_we = we;
        pico_addr = addr;
        pico_wdata = wdata;
        pico_req = 1'b1;
        @(posedge clk); #1;
        pico_req = 1'b0;
    endtask

    task automatic waitIdle();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (picoQ.size() == 0 && !pico_busy && !rtc_req) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        checkOutput("idle_reached", 32'(ok), 32'd1);
    endtask

    // RTC register model answering the bus after ackDelay cycles.
    initial begin
        busExp_t b;
        int waitCnt;
        waitCnt = 0;
        rtc_ack = 1'b0;
        rtc_rdata = 8'h00;
        for (int i = 0; i < 8; i++) regs[i] = 8'h00;
        regs[0] = 8'h59;
        regs[3] = 8'h7A;
        regs[4] = 8'h99;
        forever begin
            @(posedge clk); #1;
            if (respEnable) begin
                rtc_ack = 1'b0;
                if (rtc_req) begin
                    if (waitCnt >= ackDelay) begin
                        waitCnt = 0;
                        rtc_ack = 1'b1;
                        rtc_rdata = regs[rtc_addr[2:0]];
                        lastAckEdge = cyc + 1;
                        if (rtc_we) begin
                            checkOutput("bus_write_expected", 32'(busQ.size() > 0), 32'd1);
                            if (busQ.size() > 0) begin
                                b = busQ.pop_front();
                                checkOutput("bus_addr", 32'(rtc_addr), 32'(b.addr));
                                checkOutput("bus_wdata", 32'(rtc_wdata), 32'(b.wdata));
                            end
                            regs[rtc_addr[2:0]] = rtc_wdata;
                        end
                    end else begin
                        waitCnt++;
                    end
                end else begin
                    waitCnt = 0;
                end
            end
        end
    end

    // Monitor: pops the scoreboard whenever the DUT presents a completion.
    initial forever begin
        picoExp_t p;
        updExp_t u;
        byte tag;
        byte expTag;
        @(negedge clk);
        if (rst_n) begin
            if (pico_done || upd_valid) begin
                if (orderQ.size() > 0) begin
                    tag = pico_done ? 8'h50 : 8'h55;
                    expTag = orderQ.pop_front();
                    checkOutput("event_order", 32'(tag), 32'(expTag));
                end
            end
            if (pico_done) begin
                doneCount++;
                checkOutput("pico_done_expected", 32'(picoQ.size() > 0), 32'd1);
                if (picoQ.size() > 0) begin
                    p = picoQ.pop_front();
                    checkOutput("pico_rdata", 32'(pico_rdata), 32'(p.rdata));
                    checkOutput("pico_conv_err", 32'(conv_err), 32'(p.err));
                    if (p.latMode == 1) checkOutput("done_after_ack", 32'(cyc + 1 - lastAckEdge), 32'd2);
                    if (p.latMode == 2) checkOutput("done_after_req", 32'(cyc + 1 - p.reqEdge), 32'd1);
                end
            end
            if (upd_valid) begin
                updCount++;
                checkOutput("upd_expected", 32'(updQ.size() > 0), 32'd1);
                if (updQ.size() > 0) begin
                    u = updQ.pop_front();
                    checkOutput("upd_addr", 32'(upd_addr), 32'(u.addr));
                    checkOutput("upd_data", 32'(upd_data), 32'(u.data));
                    checkOutput("upd_conv_err", 32'(conv_err), 32'(u.err));
                end
            end
            if (conv_err && !pico_done && !upd_valid) checkOutput("conv_err_stray", 32'(conv_err), 32'd0);
        end
    end

    initial begin
        updExp_t u;
        int d0;
        int u0;
        int n;
        rst_n = 1'b0;
        pico_req = 1'b0;
        pico_we = 1'b0;
        pico_addr = 8'h00;
        pico_wdata = 8'h00;
        scan_en = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_rtc_req", 32'(rtc_req), 32'd0);
        checkOutput("rst_pico_busy", 32'(pico_busy), 32'd0);
        checkOutput("rst_pulses", 32'({pico_done, upd_valid, conv_err}), 32'd0);
        checkOutput("rst_data", 32'({pico_rdata, upd_data, rtc_wdata}), 32'd0);
        checkOutput("rst_addr", 32'({upd_addr, rtc_addr, 7'd0, rtc_we}), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        $display("[TB] pico transfers, scan disabled");
        ackDelay = 3;
        applyStimulus(1'b1, 8'd1, 8'd45, 8'h00, 1'b0, 1, 1'b1, 8'h45);
        waitIdle();
        checkOutput("reg1_written", 32'(regs[1]), 32'h45);
        ackDelay = 1;
        applyStimulus(1'b0, 8'd0, 8'd0, 8'h3B, 1'b0, 1, 1'b0, 8'h00);
        waitIdle();
        applyStimulus(1'b1, 8'd2, 8'd99, 8'h3B, RC, RC ? 2 : 1, !RC, 8'h99);
        waitIdle();
        applyStimulus(1'b1, 8'd5, 8'd100, 8'h3B, RC, RC ? 2 : 1, !RC, 8'h00);
        waitIdle();
        ackDelay = 0;
        applyStimulus(1'b0, 8'd4, 8'd0, RC ? 8'h00 : 8'h63, RC, 1, 1'b0, 8'h00);
        waitIdle();
        applyStimulus(1'b0, 8'd3, 8'd0, RC ? 8'h00 : 8'h50, RC, 1, 1'b0, 8'h00);
        waitIdle();
        applyStimulus(1'b1, 8'd6, 8'd59, RC ? 8'h00 : 8'h50, 1'b0, 1, 1'b1, 8'h59);
        waitIdle();
        applyStimulus(1'b1, 8'd7, 8'd60, RC ? 8'h00 : 8'h50, RC, RC ? 2 : 1, !RC, 8'h60);
        waitIdle();

        $display("[TB] request while busy is ignored");
        ackDelay = 5;
        d0 = doneCount;
        applyStimulus(1'b0, 8'd2, 8'd0, RC ? 8'h00 : 8'h63, 1'b0, 1, 1'b0, 8'h00);
        repeat (2) begin
            @(posedge clk); #1;
        end
        pico_we = 1'b0;
        pico_addr = 8'd0;
        pico_req = 1'b1;
        @(posedge clk); #1;
        pico_req = 1'b0;
        waitIdle();
        repeat (5) begin
            @(posedge clk); #1;
        end
        checkOutput("single_done", 32'(doneCount - d0), 32'd1);

        $display("[TB] reset during a bus cycle");
        respEnable = 1'b0;
        rtc_ack = 1'b0;
        d0 = doneCount;
        u0 = updCount;
        pico_we = 1'b0;
        pico_addr = 8'd0;
        pico_req = 1'b1;
        @(posedge clk); #1;
        pico_req = 1'b0;
        checkOutput("req_before_reset", 32'(rtc_req), 32'd1);
        rst_n = 1'b0;
        @(posedge clk); #1;
        checkOutput("req_after_reset", 32'(rtc_req), 32'd0);
        checkOutput("busy_after_reset", 32'(pico_busy), 32'd0);
        checkOutput("rdata_after_reset", 32'(pico_rdata), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        rtc_rdata = 8'h11;
        rtc_ack = 1'b1;
        @(posedge clk); #1;
        rtc_ack = 1'b0;
        repeat (6) begin
            @(posedge clk); #1;
        end
        checkOutput("no_done_after_reset", 32'(doneCount - d0), 32'd0);
        checkOutput("no_upd_after_reset", 32'(updCount - u0), 32'd0);
        checkOutput("req_idle_after_reset", 32'(rtc_req), 32'd0);
        respEnable = 1'b1;
        ackDelay = 0;

        $display("[TB] scan sequence with round-robin conflicts");
        u0 = updCount;
        orderQ.push_back(8'h50);
        orderQ.push_back(8'h55);
        orderQ.push_back(8'h50);
        orderQ.push_back(8'h55);
        orderQ.push_back(8'h55);
        u.err = 1'b0;
        u.addr = 8'd0; u.data = 8'h3B; updQ.push_back(u);
        u.addr = 8'd1; u.data = 8'h2D; updQ.push_back(u);
        u.addr = 8'd2; u.data = RC ? 8'h00 : 8'h63; updQ.push_back(u);
        scan_en = 1'b1;
        repeat (16) @(posedge clk);
        #1;
        applyStimulus(1'b0, 8'd0, 8'd0, 8'h3B, 1'b0, 0, 1'b0, 8'h00);
        applyStimulus(1'b0, 8'd6, 8'd0, 8'h3B, 1'b0, 0, 1'b0, 8'h00);
        n = 0;
        while (updCount - u0 < 3 && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        checkOutput("scan_updates", 32'(updCount - u0), 32'd3);
        scan_en = 1'b0;
        waitIdle();
        repeat (40) begin
            @(posedge clk); #1;
        end
        checkOutput("scan_pending_cleared", 32'(updCount - u0), 32'd3);

        checkOutput("pico_queue_empty", 32'(picoQ.size()), 32'd0);
        checkOutput("upd_queue_empty", 32'(updQ.size()), 32'd0);
        checkOutput("bus_queue_empty", 32'(busQ.size()), 32'd0);
        checkOutput("order_queue_empty", 32'(orderQ.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
